// File: rtl/tag_fifo_pkg.sv
// tag_fifo_pkg: rename-tag widths and types shared by dispatch, RS, CDB and the free list
package tag_fifo_pkg;
    localparam int DEF_W_TAG = 6;
    localparam int DEF_N_TAG = 2**DEF_W_TAG;
    localparam int DEF_W_CNT = DEF_W_TAG + 1;
    typedef logic [DEF_W_TAG-1:0] tag_t;
    typedef logic [DEF_W_CNT-1:0] tag_cnt_t;
endpackage

// File: rtl/tag_free_map.sv
// tag_free_map: one bit per rename tag, set while the tag sits in the free list
module tag_free_map
    import tag_fifo_pkg::*;
#(
    parameter int W_TAG = DEF_W_TAG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             set_en,
    input  logic [W_TAG-1:0] set_tag,
    input  logic             clr_en,
    input  logic [W_TAG-1:0] clr_tag,
    input  logic [W_TAG-1:0] lookup_tag,
    output logic             is_free,
    output logic [W_TAG:0]   popcount
);
    localparam int N_TAG = 2**W_TAG;

    logic [N_TAG-1:0] map;

    assign is_free = map[lookup_tag];

    // every tag starts free; a popped tag is cleared, a reclaimed tag is set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map <= '1;
        end else if (init) begin
            map <= '1;
        end else begin
            if (clr_en) map[clr_tag] <= 1'b0;
            if (set_en) map[set_tag] <= 1'b1;
        end
    end

    // number of free tags, must always equal the FIFO occupancy
    always_comb begin
        popcount = '0;
        for (int i = 0; i < N_TAG; i++) popcount = popcount + {{W_TAG{1'b0}}, map[i]};
    end
endmodule

// File: rtl/tag_fifo.sv
// tag_fifo: circular free list of rename tags, popped by dispatch and refilled from the CDB
module tag_fifo
    import tag_fifo_pkg::*;
#(
    parameter int W_TAG     = DEF_W_TAG,
    parameter bit SIM_CHECK = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_tag_req,
    output logic [W_TAG-1:0] dispatch_tag,
    output logic             dispatch_tag_valid,
    input  logic [W_TAG-1:0] cdb_tag,
    input  logic             cdb_valid,
    output logic [W_TAG:0]   tag_count,
    output logic             err_overflow,
    output logic             err_double_free
);
    localparam int N_TAG = 2**W_TAG;
    localparam logic [W_TAG:0] FULL = (W_TAG+1)'(N_TAG);

    logic [W_TAG-1:0] mem [N_TAG];
    logic [W_TAG-1:0] rd_ptr, wr_ptr;
    logic [W_TAG:0]   count, free_cnt;
    logic             full, pop, push, cdb_free, ovf_set, dbl_set;

    // a pop in the same cycle frees a slot, so a push is legal even at full
    assign full               = count == FULL;
    assign pop                = dispatch_tag_req && count != '0;
    assign push               = cdb_valid && (!full || pop) && !cdb_free;
    assign ovf_set            = cdb_valid && full && !pop;
    assign dbl_set            = cdb_valid && cdb_free;
    assign dispatch_tag       = mem[rd_ptr];
    assign dispatch_tag_valid = count != '0;
    assign tag_count          = count;

    tag_free_map #(.W_TAG(W_TAG)) u_map (
        .clk        (clk),
        .reset      (reset),
        .init       (flush),
        .set_en     (push),
        .set_tag    (cdb_tag),
        .clr_en     (pop),
        .clr_tag    (dispatch_tag),
        .lookup_tag (cdb_tag),
        .is_free    (cdb_free),
        .popcount   (free_cnt)
    );

    // tag storage: identity contents on init, reclaimed tags written at the tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAG; i++) mem[i] <= W_TAG'(i);
        end else if (flush) begin
            for (int i = 0; i < N_TAG; i++) mem[i] <= W_TAG'(i);
        end else if (push) begin
            mem[wr_ptr] <= cdb_tag;
        end
    end

    // pointers, occupancy and sticky protocol-error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= FULL;
            err_overflow    <= 1'b0;
            err_double_free <= 1'b0;
        end else if (flush) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= FULL;
            err_overflow    <= 1'b0;
            err_double_free <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + W_TAG'(1);
            if (push) wr_ptr <= wr_ptr + W_TAG'(1);
            if (push && !pop) count <= count + (W_TAG+1)'(1);
            else if (pop && !push) count <= count - (W_TAG+1)'(1);
            if (ovf_set) err_overflow <= 1'b1;
            if (dbl_set) err_double_free <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // simulation-only checker: flag-set events when SIM_CHECK is on, occupancy vs bitmap always
    always @(posedge clk) begin
        if (!reset && !flush && SIM_CHECK) begin
            if (ovf_set && !err_overflow) $display("FATAL tag_fifo: push of tag %0d while full", cdb_tag);
            if (dbl_set && !err_double_free) $display("FATAL tag_fifo: tag %0d returned while already free", cdb_tag);
        end
        if (!reset && count != free_cnt) $display("FATAL tag_fifo: count %0d disagrees with free_map popcount %0d", count, free_cnt);
    end
`endif
endmodule

// File: tb/tb_tag_fifo.sv
// tb_tag_fifo: directed and randomized checks of tag_fifo against a queue-based free-list model
module tb_tag_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       dispatch_tag_req = 1'b0;
    logic [5:0] dispatch_tag;
    logic       dispatch_tag_valid;
    logic [5:0] cdb_tag = '0;
    logic       cdb_valid = 1'b0;
    logic [6:0] tag_count;
    logic       err_overflow, err_double_free;

    int checks = 0;
    int errors = 0;

    int fq[$];
    bit fr[64];
    bit m_ovf, m_dbl;

    always #5 clk = ~clk;

    tag_fifo dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .dispatch_tag_req   (dispatch_tag_req),
        .dispatch_tag       (dispatch_tag),
        .dispatch_tag_valid (dispatch_tag_valid),
        .cdb_tag            (cdb_tag),
        .cdb_valid          (cdb_valid),
        .tag_count          (tag_count),
        .err_overflow       (err_overflow),
        .err_double_free    (err_double_free)
    );

    function automatic void model_reset();
        fq.delete();
        for (int i = 0; i < 64; i++) begin
            fq.push_back(i);
            fr[i] = 1'b1;
        end
        m_ovf = 1'b0;
        m_dbl = 1'b0;
    endfunction

    function automatic void model_step(bit req, bit cv, int ct, bit fl);
        bit p, full, acc;
        int head;
        if (fl) begin
            model_reset();
            return;
        end
        p    = req && fq.size() != 0;
        full = fq.size() == 64;
        head = p ? fq[0] : 0;
        acc  = cv && (!full || p) && !fr[ct];
        if (cv && full && !p) m_ovf = 1'b1;
        if (cv && fr[ct]) m_dbl = 1'b1;
        if (p) begin
            void'(fq.pop_front());
            fr[head] = 1'b0;
        end
        if (acc) begin
            fq.push_back(ct);
            fr[ct] = 1'b1;
        end
    endfunction

    task automatic step(input bit req, input bit cv, input int ct, input bit fl);
        dispatch_tag_req = req;
        cdb_valid = cv;
        cdb_tag = 6'(ct);
        flush = fl;
        @(posedge clk);
        model_step(req, cv, ct, fl);
        #1;
        dispatch_tag_req = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dispatch_tag_req = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dispatch_tag !== 6'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", dispatch_tag); end
        checks++; if (dispatch_tag_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %b expected 1", dispatch_tag_valid); end
        checks++; if (tag_count !== 7'd64) begin errors++; $display("FAIL reset_count: got %0d expected 64", tag_count); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", err_overflow); end
        checks++; if (err_double_free !== 1'b0) begin errors++; $display("FAIL reset_dbl: got %b expected 0", err_double_free); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 64; i++) begin
            checks++; if (dispatch_tag !== 6'(i)) begin errors++; $display("FAIL drain_tag[%0d]: got %0d expected %0d", i, dispatch_tag, i); end
            checks++; if (tag_count !== 7'(64 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, tag_count, 64 - i); end
            checks++; if (dispatch_tag_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, dispatch_tag_valid); end
            step(1, 0, 0, 0);
        end
        checks++; if (dispatch_tag_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b expected 0", dispatch_tag_valid); end
        checks++; if (tag_count !== 7'd0) begin errors++; $display("FAIL drain_empty_count: got %0d expected 0", tag_count); end
        step(1, 0, 0, 0);
        checks++; if (tag_count !== 7'd0) begin errors++; $display("FAIL pop_empty_count: got %0d expected 0", tag_count); end
        checks++; if ({err_overflow, err_double_free} !== 2'b00) begin errors++; $display("FAIL drain_flags: got %b expected 00", {err_overflow, err_double_free}); end
    endtask

    task automatic test_refill();
        step(0, 1, 17, 0);
        checks++; if (dispatch_tag !== 6'd17) begin errors++; $display("FAIL refill_tag: got %0d expected 17", dispatch_tag); end
        checks++; if (dispatch_tag_valid !== 1'b1) begin errors++; $display("FAIL refill_valid: got %b expected 1", dispatch_tag_valid); end
        checks++; if (tag_count !== 7'd1) begin errors++; $display("FAIL refill_count: got %0d expected 1", tag_count); end
        step(1, 0, 0, 0);
        checks++; if (tag_count !== 7'd0) begin errors++; $display("FAIL refill_pop_count: got %0d expected 0", tag_count); end
        checks++; if (dispatch_tag_valid !== 1'b0) begin errors++; $display("FAIL refill_pop_valid: got %b expected 0", dispatch_tag_valid); end
    endtask

    task automatic test_pop_push();
        step(0, 1, 5, 0);
        step(0, 1, 8, 0);
        step(1, 1, 9, 0);
        checks++; if (tag_count !== 7'd2) begin errors++; $display("FAIL pp_count: got %0d expected 2", tag_count); end
        checks++; if (dispatch_tag !== 6'd8) begin errors++; $display("FAIL pp_head: got %0d expected 8", dispatch_tag); end
        checks++; if (dut.u_map.map[5] !== 1'b0) begin errors++; $display("FAIL pp_map5: got %b expected 0", dut.u_map.map[5]); end
        checks++; if (dut.u_map.map[9] !== 1'b1) begin errors++; $display("FAIL pp_map9: got %b expected 1", dut.u_map.map[9]); end
        checks++; if ({err_overflow, err_double_free} !== 2'b00) begin errors++; $display("FAIL pp_flags: got %b expected 00", {err_overflow, err_double_free}); end
        step(1, 0, 0, 0);
        checks++; if (dispatch_tag !== 6'd9) begin errors++; $display("FAIL pp_tail: got %0d expected 9", dispatch_tag); end
        step(1, 0, 0, 0);
        checks++; if (tag_count !== 7'd0) begin errors++; $display("FAIL pp_drain: got %0d expected 0", tag_count); end
    endtask

    task automatic test_double_free_after_reset();
        do_reset();
        step(0, 1, 3, 0);
        checks++; if (err_double_free !== 1'b1) begin errors++; $display("FAIL df_flag: got %b expected 1", err_double_free); end
        checks++; if (err_overflow !== m_ovf) begin errors++; $display("FAIL df_ovf: got %b expected %b", err_overflow, m_ovf); end
        checks++; if (tag_count !== 7'd64) begin errors++; $display("FAIL df_count: got %0d expected 64", tag_count); end
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++; if (err_double_free !== 1'b1) begin errors++; $display("FAIL df_sticky: got %b expected 1", err_double_free); end
        checks++; if (dispatch_tag !== 6'd1) begin errors++; $display("FAIL df_head: got %0d expected 1", dispatch_tag); end
    endtask

    task automatic test_full_pop_push();
        do_reset();
        step(1, 1, 0, 0);
        checks++; if (err_double_free !== 1'b1) begin errors++; $display("FAIL fpp_dbl: got %b expected 1", err_double_free); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", err_overflow); end
        checks++; if (tag_count !== 7'd63) begin errors++; $display("FAIL fpp_count: got %0d expected 63", tag_count); end
        step(0, 1, 0, 0);
        checks++; if (tag_count !== 7'd64) begin errors++; $display("FAIL fpp_refill: got %0d expected 64", tag_count); end
        checks++; if (dut.wr_ptr !== 6'd1) begin errors++; $display("FAIL fpp_wrptr: got %0d expected 1", dut.wr_ptr); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf2: got %b expected 0", err_overflow); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (dispatch_tag !== 6'((i + 1) % 64)) begin errors++; $display("FAIL fpp_order[%0d]: got %0d expected %0d", i, dispatch_tag, (i + 1) % 64); end
            step(1, 0, 0, 0);
        end
    endtask

    task automatic test_flush_midop();
        do_reset();
        for (int i = 0; i < 50; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 1, i, 0);
        for (int i = 0; i < 44; i++) step(1, 0, 0, 0);
        checks++; if (tag_count !== 7'd20) begin errors++; $display("FAIL mid_count: got %0d expected 20", tag_count); end
        checks++; if (dispatch_tag !== 6'd30) begin errors++; $display("FAIL mid_head: got %0d expected 30", dispatch_tag); end
        step(0, 1, 40, 0);
        checks++; if (err_double_free !== 1'b1) begin errors++; $display("FAIL mid_dbl: got %b expected 1", err_double_free); end
        step(1, 1, 5, 1);
        checks++; if (tag_count !== 7'd64) begin errors++; $display("FAIL flush_count: got %0d expected 64", tag_count); end
        checks++; if (dispatch_tag !== 6'd0) begin errors++; $display("FAIL flush_tag: got %0d expected 0", dispatch_tag); end
        checks++; if ({err_overflow, err_double_free} !== 2'b00) begin errors++; $display("FAIL flush_flags: got %b expected 00", {err_overflow, err_double_free}); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (dispatch_tag !== 6'(i)) begin errors++; $display("FAIL flush_mem[%0d]: got %0d expected %0d", i, dispatch_tag, i); end
            step(1, 0, 0, 0);
        end
        step(0, 1, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dispatch_tag !== 6'd0) begin errors++; $display("FAIL async_tag: got %0d expected 0", dispatch_tag); end
        checks++; if (tag_count !== 7'd64) begin errors++; $display("FAIL async_count: got %0d expected 64", tag_count); end
        checks++; if (dispatch_tag_valid !== 1'b1) begin errors++; $display("FAIL async_valid: got %b expected 1", dispatch_tag_valid); end
        checks++; if (err_double_free !== 1'b0) begin errors++; $display("FAIL async_dbl: got %b expected 0", err_double_free); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, int'($urandom_range(0, 63)), $urandom_range(0, 249) == 0);
            checks++; if (tag_count !== 7'(fq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, tag_count, fq.size()); end
            checks++; if (dispatch_tag_valid !== (fq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, dispatch_tag_valid, fq.size() != 0); end
            if (fq.size() != 0) begin
                checks++; if (dispatch_tag !== 6'(fq[0])) begin errors++; $display("FAIL rnd_tag[%0d]: got %0d expected %0d", n, dispatch_tag, fq[0]); end
            end
            checks++; if (err_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", n, err_overflow, m_ovf); end
            checks++; if (err_double_free !== m_dbl) begin errors++; $display("FAIL rnd_dbl[%0d]: got %b expected %b", n, err_double_free, m_dbl); end
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_refill();
        test_pop_push();
        test_double_free_after_reset();
        test_full_pop_push();
        test_flush_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
